griffin_sponge: RTL and testbench

//  Initiator for the griffin permutation engine's enable/done interface. Hashes a stream
//  of field elements: absorbs RATE elements per block by modular addition into the rate

---
 rtl/griffin_sponge.sv | 125 ++++++++++++
 tb/tb_griffin_sponge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/griffin_sponge.sv
// griffin_sponge: sponge hash initiator for griffin (watchdog enabled by GRIFFIN_SPONGE_WDOG_EN)
module griffin_sponge #(
  parameter int N_BITS = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter int STATE_SIZE = 3
`ifdef GRIFFIN_SPONGE_WDOG_EN
  , parameter int WDOG_CYCLES = 4096
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [N_BITS-1:0]                    in_data,
  input  logic                                 in_last,
  output logic                                 perm_enable,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]    perm_state_out,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]    perm_state_in,
  input  logic                                 perm_done,
  output logic                                 digest_valid,
  input  logic                                 digest_ready,
  output logic [N_BITS-1:0]                    digest,
  output logic                                 wdog_err
);
  localparam int RATE = STATE_SIZE - 1;
  localparam int FW = $clog2(STATE_SIZE);
  localparam logic [FW-1:0] RATE_F = FW'(RATE);
  localparam logic [N_BITS-1:0] ONE = 1;
  localparam logic [2:0] ABSORB = 3'd0, PERM_REQ = 3'd1, PERM_WAIT = 3'd2, PAD_REQ = 3'd3, OUTPUT = 3'd4;
  logic [STATE_SIZE-1:0][N_BITS-1:0] lane_q, lane_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [2:0] st_q, st_d;
  logic fin_q, fin_d, pad_q, pad_d;
`ifdef GRIFFIN_SPONGE_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign wdog_err = err_q;
`else
  assign wdog_err = 1'b0;
`endif
  function automatic logic [N_BITS-1:0] addmod(input logic [N_BITS-1:0] a, input logic [N_BITS-1:0] b);
    logic [N_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, PRIME_MODULUS}) ? N_BITS'(s - {1'b0, PRIME_MODULUS}) : s[N_BITS-1:0];
  endfunction
  assign in_ready = st_q == ABSORB;
  assign perm_enable = st_q == PERM_REQ || st_q == PAD_REQ;
  assign perm_state_out = lane_q;
  assign digest_valid = st_q == OUTPUT;
  assign digest = digest_valid ? lane_q[0] : '0;
  // next-state: absorb/pad in ABSORB, load griffin result (plus pad block) on perm_done, clear on digest handshake
  always_comb begin
    lane_d = lane_q;
    fill_d = fill_q;
    fin_d = fin_q;
    pad_d = pad_q;
    st_d = st_q;
`ifdef GRIFFIN_SPONGE_WDOG_EN
    cnt_d = '0;
    err_d = err_q;
`endif
    case (st_q)
      ABSORB: if (in_valid) begin
        lane_d[fill_q] = addmod(lane_q[fill_q], in_data);
        fill_d = fill_q + 1'b1;
        if (in_last && fill_d != RATE_F) lane_d[fill_d] = addmod(lane_d[fill_d], ONE);
        fin_d = in_last && fill_d != RATE_F;
        pad_d = in_last && fill_d == RATE_F;
        st_d = (in_last || fill_d == RATE_F) ? PERM_REQ : ABSORB;
      end
      PERM_REQ, PAD_REQ: st_d = PERM_WAIT;
      PERM_WAIT: if (perm_done) begin
        lane_d = perm_state_in;
        if (pad_q) lane_d[0] = addmod(perm_state_in[0], ONE);
        fill_d = '0;
        fin_d = fin_q || pad_q;
        pad_d = 1'b0;
        st_d = fin_q ? OUTPUT : pad_q ? PAD_REQ : ABSORB;
      end
`ifdef GRIFFIN_SPONGE_WDOG_EN
      else if (cnt_q == CW'(WDOG_CYCLES - 1)) begin
        lane_d = '0;
        fill_d = '0;
        fin_d = 1'b0;
        pad_d = 1'b0;
        err_d = 1'b1;
        st_d = ABSORB;
      end else cnt_d = cnt_q + 1'b1;
`endif
      OUTPUT: if (digest_ready) begin
        lane_d = '0;
        fill_d = '0;
        fin_d = 1'b0;
        pad_d = 1'b0;
        st_d = ABSORB;
      end
      default: st_d = ABSORB;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      fill_q <= '0;
      fin_q <= 1'b0;
      pad_q <= 1'b0;
      st_q <= ABSORB;
`ifdef GRIFFIN_SPONGE_WDOG_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      lane_q <= lane_d;
      fill_q <= fill_d;
      fin_q <= fin_d;
      pad_q <= pad_d;
      st_q <= st_d;
`ifdef GRIFFIN_SPONGE_WDOG_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_griffin_sponge.sv
// tb_griffin_sponge: directed scoreboard bench acting as host, griffin model and digest consumer
module tb_griffin_sponge;
  localparam int N = 254;
  localparam int W = 3 * N;
  localparam logic [N-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  typedef logic [2:0][N-1:0] st_t;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, perm_done = 1'b0, digest_ready = 1'b0;
  logic [N-1:0] in_data = '0;
  st_t perm_state_in = '0;
  logic in_ready, perm_enable, digest_valid, wdog_err;
  st_t perm_state_out;
  logic [N-1:0] digest;
  int tests = 0, fails = 0;
  logic [N-1:0] sb[$];

`ifdef GRIFFIN_SPONGE_WDOG_EN
  griffin_sponge #(.WDOG_CYCLES(16)) dut (
`else
  griffin_sponge dut (
`endif
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .perm_enable(perm_enable), .perm_state_out(perm_state_out),
    .perm_state_in(perm_state_in), .perm_done(perm_done), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .digest(digest), .wdog_err(wdog_err));

  always #5 clk = ~clk;

  function automatic st_t mk(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    mk = {c, b, a};
  endfunction

  function automatic logic [N-1:0] fsum(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, P};
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] rnd();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r[N-1:0] % P;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [N-1:0] d, input logic l);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("beat_ready", W'(in_ready), W'(1'b1));
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic perm(input string tag, input st_t exp, input st_t ret, input int hold);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!perm_enable && k < 20);
    chk({tag, "_en"}, W'(perm_enable), W'(1'b1));
    chk({tag, "_st"}, perm_state_out, exp);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold"}, W'({perm_enable, in_ready}), W'(2'b00));
      chk({tag, "_stable"}, perm_state_out, exp);
    end
    perm_state_in = ret;
    perm_done = 1'b1;
    @(posedge clk);
    #1 perm_done = 1'b0;
  endtask

  task automatic dig(input string tag, input int stall);
    logic [N-1:0] e;
    int k;
    k = 0;
    tests++;
    assert (sb.size() > 0) else begin
      fails++;
      $error("FAIL %s_sb: observed %0d expected >0 queued digests", tag, sb.size());
    end
    e = sb.pop_front();
    do begin
      @(negedge clk);
      k++;
    end while (!digest_valid && k < 20);
    chk({tag, "_lat"}, W'(k), W'(1));
    chk({tag, "_dig"}, W'({digest_valid, digest}), W'({1'b1, e}));
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_stall"}, W'({digest_valid, digest}), W'({1'b1, e}));
    end
    digest_ready = 1'b1;
    @(posedge clk);
    #1 digest_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_clr"}, W'({digest_valid, in_ready, digest}), W'({2'b01, {N{1'b0}}}));
    chk({tag, "_clr_st"}, perm_state_out, '0);
  endtask

  initial begin
    logic [N-1:0] r1, r2, r3, u, v, w, q;
    repeat (2) @(negedge clk);
    chk("rst_ctl", W'({in_ready, perm_enable, digest_valid, wdog_err}), W'(4'b1000));
    chk("rst_st", perm_state_out, '0);
    chk("rst_dig", W'(digest), '0);
    reset = 1'b0;
    beat(254'd5, 1'b1);
    in_valid = 1'b1;
    in_data = 254'd7;
    perm("t1", mk(254'd5, 254'd1, 254'd0), mk(P - 254'd3, 254'd22, 254'd33), 3);
    in_valid = 1'b0;
    sb.push_back(P - 254'd3);
    dig("t1", 5);
    beat(254'd3, 1'b0);
    beat(254'd4, 1'b1);
    perm("t2a", mk(254'd3, 254'd4, 254'd0), mk(P - 254'd1, 254'd77, 254'd88), 1);
    perm("t2b", mk(254'd0, 254'd77, 254'd88), mk(254'h2abcdef, 254'd1, 254'd2), 1);
    sb.push_back(254'h2abcdef);
    dig("t2", 0);
    beat(254'd10, 1'b0);
    beat(254'd20, 1'b0);
    perm("t3a", mk(254'd10, 254'd20, 254'd0), mk(P - 254'd1, 254'd5, 254'd6), 1);
    beat(254'd2, 1'b1);
    perm("t3b", mk(254'd1, 254'd6, 254'd6), mk(254'd999, 254'd0, P - 254'd1), 1);
    sb.push_back(254'd999);
    dig("t3", 1);
    for (int i = 0; i < 2; i++) begin
      r1 = rnd(); r2 = rnd(); r3 = rnd(); u = rnd(); v = rnd(); w = rnd(); q = rnd();
      beat(r1, 1'b0);
      beat(r2, 1'b0);
      perm("t4a", mk(r1, r2, 254'd0), mk(u, v, w), 1);
      beat(r3, 1'b1);
      perm("t4b", mk(fsum(u, r3), fsum(v, 254'd1), w), mk(q, r1, r2), 2);
      sb.push_back(q);
      dig("t4", 2);
    end
    beat(254'd9, 1'b1);
    @(negedge clk);
    chk("t5_en", W'(perm_enable), W'(1'b1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    perm_state_in = mk(254'd1, 254'd2, 254'd3);
    perm_done = 1'b1;
    @(posedge clk);
    #1 perm_done = 1'b0;
    @(negedge clk);
    chk("t5_ctl", W'({in_ready, perm_enable, digest_valid}), W'(3'b100));
    chk("t5_st", perm_state_out, '0);
    beat(254'd11, 1'b1);
    perm("t5", mk(254'd11, 254'd1, 254'd0), mk(254'd4242, 254'd3, 254'd4), 1);
    sb.push_back(254'd4242);
    dig("t5", 0);
`ifdef GRIFFIN_SPONGE_WDOG_EN
    beat(254'd13, 1'b1);
    @(negedge clk);
    chk("t6_en", W'(perm_enable), W'(1'b1));
    repeat (16) @(negedge clk);
    chk("t6_pre", W'({wdog_err, in_ready}), W'(2'b00));
    @(negedge clk);
    chk("t6_trip", W'({wdog_err, in_ready}), W'(2'b11));
    chk("t6_st", perm_state_out, '0);
    repeat (3) @(negedge clk);
    chk("t6_sticky", W'(wdog_err), W'(1'b1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst", W'(wdog_err), W'(1'b0));
`else
    chk("t6_tied", W'(wdog_err), W'(1'b0));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
